rate_controller: RTL
====================

RATE_CONTROLLER -- requirements
Module: rate_controller

Interface
REQ-001 Parameter DEFAULT_DIV, default 5_000_000: divide value loaded at reset.
REQ-002 Parameter CNT_W, default 32: width of divide value and period counter.
REQ-003 Port clock_in  input  1: single system clock; all logic SHALL be on its rising edge.
REQ-004 Port reset_n  input  1: reset, synchronous, active-low.
REQ-005 Port div_value  input  CNT_W: new divide value, sampled only when div_load=1.
REQ-006 Port div_load  input  1: single-cycle request to load div_value.
REQ-007 Port div_ack  output  1: one-cycle pulse when the pending value is committed.
REQ-008 Port run  input  1: level; continuous ticking while high.
REQ-009 Port step  input  1: single-cycle request for exactly one period and one tick.
REQ-010 Port tick  output  1: registered one-cycle enable pulse, once per period.
REQ-011 Port clock_out  output  1: registered square wave, toggles on every tick.
REQ-012 Port busy  output  1: high in RUN, STEP or LOAD.
REQ-013 Port state  output  2: IDLE=00, RUN=01, STEP=10, LOAD=11.

Function
REQ-014 Effective divide eff_div SHALL be div_reg, except div_reg=0 SHALL be treated as 1.
REQ-015 Period counter cnt SHALL be 0 on the first cycle in RUN or STEP, increment by 1 per cycle, and wrap to 0 after reaching eff_div-1.
REQ-016 The cycle with cnt=eff_div-1 in RUN/STEP is a boundary; tick SHALL be 1 in the next cycle only, so the first tick is eff_div cycles after entry and later ticks every eff_div cycles.
REQ-017 clock_out SHALL toggle in the same cycle tick is asserted; with eff_div=1 in RUN, tick stays 1 and clock_out toggles every cycle.
REQ-018 IDLE: priority pending_load > step > run; pending_load -> LOAD, step -> STEP, run=1 -> RUN; otherwise remain; cnt held at 0.
REQ-019 RUN: run=0 -> IDLE next cycle, cnt cleared, clock_out keeps its level, no tick; a boundary with pending_load set -> LOAD.
REQ-020 STEP: at the boundary -> IDLE, or LOAD if pending_load; run and step are ignored in STEP.
REQ-021 step while RUN SHALL be ignored and not remembered.
REQ-022 div_load in any state SHALL capture div_value into pending_val and set pending_load; a later div_load before commit overwrites pending_val with one ack total.
REQ-023 LOAD lasts exactly one cycle: div_reg<=pending_val, pending_load<=0, cnt<=0, div_ack=1 next cycle; then -> RUN if run=1, else IDLE.
REQ-024 div_load in the same cycle as the LOAD commit SHALL be captured as a new pending request and not lost.
REQ-025 A value change never shortens a period in progress; the new eff_div applies from the first period after LOAD.
REQ-026 cnt compare SHALL be unsigned CNT_W-bit with no overflow; DEFAULT_DIV SHALL fit in CNT_W bits.

Reset
REQ-027 With reset_n=0 at a rising edge: state=IDLE, cnt=0, div_reg=DEFAULT_DIV, pending_load=0, pending_val=0, tick=0, clock_out=0, div_ack=0, busy=0.
REQ-028 Reset SHALL override every state including mid-period and LOAD; a pending load is discarded without ack.
REQ-029 Outputs SHALL change only on clock_in edges; reset_n has no asynchronous effect.

Verification
REQ-030 Reset, load 4, run=1 -> div_ack once, then ticks at cycles 4, 8, 12 after RUN entry; clock_out period 8 cycles.
REQ-031 IDLE, div=3, step pulse -> one tick 3 cycles later, state returns 00, no more ticks; step during RUN -> no extra tick.
REQ-032 RUN with div=10, div_load 2 at cnt=3 -> ack after the cnt=9 boundary, following ticks spaced 2.
REQ-033 Load 0, run=1 -> tick continuously 1, clock_out toggles every cycle.
REQ-034 Two div_load (5 then 7) during one period -> single ack, eff_div=7.
REQ-035 reset_n low for one edge mid-RUN with a pending load -> all outputs at reset values next cycle, no div_ack, div_reg=DEFAULT_DIV.

Source files
------------

// File: rtl/rate_controller.sv
// rate_controller: programmable tick / clock divider with free-run, single-step and deferred divide loading.
//   clock_in  : system clock, all logic on its rising edge
//   reset_n   : synchronous active-low reset
//   div_value : new divide value, captured when div_load=1
//   div_load  : single-cycle request to load div_value
//   div_ack   : one-cycle pulse when the pending value is committed
//   run       : level, continuous ticking while high
//   step      : single-cycle request for one period and one tick
//   tick      : one-cycle enable pulse per period
//   clock_out : square wave toggling on every tick
//   busy      : high whenever state is not IDLE
//   state     : IDLE=00, RUN=01, STEP=10, LOAD=11
module rate_controller #(
   parameter int CNT_W = 32,
   parameter int unsigned DEFAULT_DIV = 5_000_000
)(
   input  logic             clock_in,
   input  logic             reset_n,
   input  logic [CNT_W-1:0] div_value,
   input  logic             div_load,
   output logic             div_ack,
   input  logic             run,
   input  logic             step,
   output logic             tick,
   output logic             clock_out,
   output logic             busy,
   output logic [1:0]       state
);
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STEP = 2'b10, LOAD = 2'b11} state_t;
   state_t cur, nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, div_reg, pending_val, eff_div;
   logic pending_load, counting, at_end, boundary;
   // a zero divide behaves as divide-by-one
   assign eff_div  = (div_reg == '0) ? CNT_W'(1) : div_reg;
   assign at_end   = cnt == eff_div - CNT_W'(1);
   // dropping run ends RUN immediately, so that cycle never counts or ticks
   assign counting = (cur == RUN && run) || cur == STEP;
   assign boundary = counting && at_end;
   assign cnt_nxt  = (counting && !at_end) ? cnt + CNT_W'(1) : '0;
   assign busy     = cur != IDLE;
   assign state    = cur;
   always_comb begin
      nxt = cur;
      case (cur)
         IDLE:    nxt = pending_load ? LOAD : step ? STEP : run ? RUN : IDLE;
         RUN:     nxt = !run ? IDLE : (boundary && pending_load) ? LOAD : RUN;
         STEP:    nxt = boundary ? (pending_load ? LOAD : IDLE) : STEP;
         default: nxt = run ? RUN : IDLE;
      endcase
   end
   always_ff @(posedge clock_in) begin
      if (!reset_n) begin
         cur          <= IDLE;
         cnt          <= '0;
         div_reg      <= CNT_W'(DEFAULT_DIV);
         pending_load <= 1'b0;
         pending_val  <= '0;
         tick         <= 1'b0;
         clock_out    <= 1'b0;
         div_ack      <= 1'b0;
      end else begin
         cur       <= nxt;
         cnt       <= cnt_nxt;
         tick      <= boundary;
         clock_out <= clock_out ^ boundary;
         div_ack   <= cur == LOAD;
         if (cur == LOAD) div_reg <= pending_val;
         // a request arriving during the commit cycle becomes the next pending load
         if (div_load) begin
            pending_val  <= div_value;
            pending_load <= 1'b1;
         end else if (cur == LOAD) begin
            pending_load <= 1'b0;
         end
      end
   end
endmodule
